// File: rtl/moore_run_counter_if.sv
// Handshake bundle for moore_run_counter: qualified input and controls in,
// registered count and decoded flags out.
interface moore_run_counter_if #(
  parameter int STATE_W = 3
);
  logic               inpt;
  logic               en;
  logic               clear;
  logic [STATE_W-1:0] outpt;
  logic               at_thresh;
  logic               at_max;
  logic               wrapped;

  modport master (output inpt, en, clear, input outpt, at_thresh, at_max, wrapped);
  modport slave  (input inpt, en, clear, output outpt, at_thresh, at_max, wrapped);
endinterface

// File: rtl/moore_run_counter.sv
// Parametrised Moore run counter: inpt=1 advances the state, inpt=0 resets
// (MODE=0) or holds (MODE=1); saturates or wraps at MAX_STATE.
module moore_run_counter #(
  parameter int STATE_W   = 3,
  parameter int MAX_STATE = 5,
  parameter int THRESH    = 3,
  parameter int WRAP      = 0,
  parameter int MODE      = 0
) (
  input  logic clk,
  input  logic reset,
  moore_run_counter_if.slave bus
);

  if (MAX_STATE < 1 || MAX_STATE > (2**STATE_W) - 1) begin : g_bad_max
    $error("moore_run_counter: MAX_STATE out of range");
  end
  if (THRESH < 1 || THRESH > MAX_STATE) begin : g_bad_thresh
    $error("moore_run_counter: THRESH out of range");
  end

  localparam logic [STATE_W-1:0] S_ZERO = '0;
  localparam logic [STATE_W-1:0] S_MAX  = STATE_W'(MAX_STATE);
  localparam logic [STATE_W-1:0] S_THR  = STATE_W'(THRESH);
  localparam logic [STATE_W-1:0] S_ONE  = STATE_W'(1);

  logic [STATE_W-1:0] state, state_nxt;
  logic               wrapped, wrapped_nxt;

  always_comb begin
    state_nxt   = state;
    wrapped_nxt = 1'b0;
    if (bus.clear) begin
      state_nxt = S_ZERO;
    end else if (bus.en) begin
      // an unreachable state (e.g. upset) is flushed on the next enabled edge
      if (state > S_MAX) begin
        state_nxt = S_ZERO;
      end else if (bus.inpt) begin
        if (state == S_MAX) begin
          if (WRAP != 0) begin
            state_nxt   = S_ZERO;
            wrapped_nxt = 1'b1;
          end else begin
            state_nxt = S_MAX;
          end
        end else begin
          state_nxt = state + S_ONE;
        end
      end else if (MODE == 0) begin
        state_nxt = S_ZERO;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_ZERO;
      wrapped <= 1'b0;
    end else begin
      state   <= state_nxt;
      wrapped <= wrapped_nxt;
    end
  end

  // flags decode registered state only
  assign bus.outpt     = state;
  assign bus.at_thresh = (state >= S_THR);
  assign bus.at_max    = (state == S_MAX);
  assign bus.wrapped   = wrapped;

endmodule

// File: tb/tb_moore_run_counter.sv
// Directed bench: three configurations (saturate/run-length, wrap, hold mode)
// driven with identical stimulus and checked against hand-computed values.
module tb_moore_run_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  moore_run_counter_if #(.STATE_W(3)) if0 ();
  moore_run_counter_if #(.STATE_W(3)) ifw ();
  moore_run_counter_if #(.STATE_W(3)) ifm ();

  moore_run_counter #(.STATE_W(3), .MAX_STATE(5), .THRESH(3), .WRAP(0), .MODE(0))
    u_d0 (.clk(clk), .reset(reset), .bus(if0.slave));
  moore_run_counter #(.STATE_W(3), .MAX_STATE(5), .THRESH(3), .WRAP(1), .MODE(0))
    u_dw (.clk(clk), .reset(reset), .bus(ifw.slave));
  moore_run_counter #(.STATE_W(3), .MAX_STATE(5), .THRESH(3), .WRAP(0), .MODE(1))
    u_dm (.clk(clk), .reset(reset), .bus(ifm.slave));

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic i, input logic e, input logic c);
    if0.inpt = i; if0.en = e; if0.clear = c;
    ifw.inpt = i; ifw.en = e; ifw.clear = c;
    ifm.inpt = i; ifm.en = e; ifm.clear = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".d0.out"}, int'(if0.outpt), 0);
    chk({tag, ".d0.th"},  int'(if0.at_thresh), 0);
    chk({tag, ".d0.max"}, int'(if0.at_max), 0);
    chk({tag, ".dw.out"}, int'(ifw.outpt), 0);
    chk({tag, ".dw.wr"},  int'(ifw.wrapped), 0);
    chk({tag, ".dm.out"}, int'(ifm.outpt), 0);
  endtask

  int e_out0 [7] = '{1, 2, 3, 4, 5, 5, 5};
  int e_th0  [7] = '{0, 0, 1, 1, 1, 1, 1};
  int e_mx0  [7] = '{0, 0, 0, 0, 1, 1, 1};
  int e_outw [7] = '{1, 2, 3, 4, 5, 0, 1};
  int e_thw  [7] = '{0, 0, 1, 1, 1, 0, 0};
  int e_mxw  [7] = '{0, 0, 0, 0, 1, 0, 0};
  int e_wrw  [7] = '{0, 0, 0, 0, 0, 1, 0};

  initial begin
    drive(1'b0, 1'b1, 1'b0);
    #2;
    chk_zero("reset");
    #10;
    reset = 1'b0;

    // idle input keeps everything at zero
    for (int k = 0; k < 3; k++) begin
      step();
      chk_zero($sformatf("idle%0d", k));
    end

    // run of ones: saturate vs wrap
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step();
      chk($sformatf("run%0d.d0.out", k), int'(if0.outpt), e_out0[k]);
      chk($sformatf("run%0d.d0.th", k),  int'(if0.at_thresh), e_th0[k]);
      chk($sformatf("run%0d.d0.max", k), int'(if0.at_max), e_mx0[k]);
      chk($sformatf("run%0d.d0.wr", k),  int'(if0.wrapped), 0);
      chk($sformatf("run%0d.dw.out", k), int'(ifw.outpt), e_outw[k]);
      chk($sformatf("run%0d.dw.th", k),  int'(ifw.at_thresh), e_thw[k]);
      chk($sformatf("run%0d.dw.max", k), int'(ifw.at_max), e_mxw[k]);
      chk($sformatf("run%0d.dw.wr", k),  int'(ifw.wrapped), e_wrw[k]);
      chk($sformatf("run%0d.dm.out", k), int'(ifm.outpt), e_out0[k]);
    end

    // inpt=0 from 4: run-length drops, hold mode keeps; then en=0 freezes
    drive(1'b0, 1'b1, 1'b1);
    step();
    chk("clr.d0.out", int'(if0.outpt), 0);
    chk("clr.dm.out", int'(ifm.outpt), 0);
    drive(1'b1, 1'b1, 1'b0);
    repeat (4) step();
    chk("to4.d0.out", int'(if0.outpt), 4);
    chk("to4.dm.out", int'(ifm.outpt), 4);
    drive(1'b0, 1'b1, 1'b0);
    step();
    chk("zero.d0.out", int'(if0.outpt), 0);
    chk("zero.dm.out", int'(ifm.outpt), 4);
    chk("zero.dm.th",  int'(ifm.at_thresh), 1);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("hold%0d.d0.out", k), int'(if0.outpt), 0);
      chk($sformatf("hold%0d.dm.out", k), int'(ifm.outpt), 4);
    end

    // clear overrides inpt/en, then counting resumes
    drive(1'b0, 1'b1, 1'b1);
    step();
    drive(1'b1, 1'b1, 1'b0);
    repeat (3) step();
    chk("pre_clr.d0.out", int'(if0.outpt), 3);
    drive(1'b1, 1'b1, 1'b1);
    step();
    chk("clr3.d0.out", int'(if0.outpt), 0);
    chk("clr3.d0.th",  int'(if0.at_thresh), 0);
    drive(1'b1, 1'b1, 1'b0);
    step();
    chk("res1.d0.out", int'(if0.outpt), 1);
    step();
    chk("res2.d0.out", int'(if0.outpt), 2);

    // clear at MAX with inpt=1 in wrap mode: no wrapped pulse
    repeat (3) step();
    chk("atmax.dw.out", int'(ifw.outpt), 5);
    drive(1'b1, 1'b1, 1'b1);
    step();
    chk("clrmax.dw.out", int'(ifw.outpt), 0);
    chk("clrmax.dw.wr",  int'(ifw.wrapped), 0);

    // async reset between edges at outpt=4
    drive(1'b1, 1'b1, 1'b0);
    repeat (4) step();
    chk("pre_rst.d0.out", int'(if0.outpt), 4);
    #2 reset = 1'b1;
    #1;
    chk_zero("midrst");
    chk("midrst.dm.th", int'(ifm.at_thresh), 0);
    #1 reset = 1'b0;
    step();
    chk("post_rst.d0.out", int'(if0.outpt), 1);
    chk("post_rst.dw.out", int'(ifw.outpt), 1);

    // reset kills a live wrapped pulse
    repeat (5) step();
    chk("wrap2.dw.out", int'(ifw.outpt), 0);
    chk("wrap2.dw.wr",  int'(ifw.wrapped), 1);
    #2 reset = 1'b1;
    #1;
    chk("wrst.dw.wr", int'(ifw.wrapped), 0);
    #1 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0);
    step();
    chk("wrst_after.dw.wr", int'(ifw.wrapped), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
